// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller slice.
package pipe_ctrl_pkg;

  // Architectural register index width (x0..x31).
  localparam int REG_W = 5;

  // Default number of cycles a data-memory access may wait before abort.
  localparam int DEF_MEM_TIMEOUT = 64;

  // Sequencer state: normal flow, or frozen waiting on data memory.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-register control bundle between the datapath and the hazard controller.
interface pipe_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
);
  // Pipeline status observed by the controller
  logic [REG_W-1:0] ifid_rs1;
  logic [REG_W-1:0] ifid_rs2;
  logic             idex_memread;
  logic [REG_W-1:0] idex_rd;
  logic             exmem_branch;
  logic             exmem_zero;
  logic             exmem_memread;
  logic             exmem_memwrite;
  logic             dmem_ready;
  // Controls returned to the datapath
  logic             pc_write;
  logic             pc_src;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_flush;
  logic             exmem_write;
  logic             exmem_flush;
  logic             dmem_req;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;

  // Datapath side: supplies status, consumes controls.
  modport master (
    output ifid_rs1, ifid_rs2, idex_memread, idex_rd, exmem_branch, exmem_zero,
           exmem_memread, exmem_memwrite, dmem_ready,
    input  pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, exmem_flush, dmem_req, mem_err, stall_cycles
  );

  // Controller side.
  modport slave (
    input  ifid_rs1, ifid_rs2, idex_memread, idex_rd, exmem_branch, exmem_zero,
           exmem_memread, exmem_memwrite, dmem_ready,
    output pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, exmem_flush, dmem_req, mem_err, stall_cycles
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in ID/EX writing a register the ID instruction reads.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  output logic             load_use
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = idex_memread && (idex_rd != {REG_W{1'b0}}) &&
                    ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: memory freeze > taken branch > load-use bubble.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = 16
)(
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int               WC_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic memop_s, taken_s, load_use_s, timeout_s, freeze_s;
  logic pc_write_s, pc_src_s, ifid_write_s, ifid_flush_s;
  logic idex_write_s, idex_flush_s, exmem_write_s, exmem_flush_s, dmem_req_s;

  hazard_detect u_hazard_detect (
    .ifid_rs1     (bus.ifid_rs1),
    .ifid_rs2     (bus.ifid_rs2),
    .idex_memread (bus.idex_memread),
    .idex_rd      (bus.idex_rd),
    .load_use     (load_use_s)
  );

  assign memop_s   = bus.exmem_memread | bus.exmem_memwrite;
  assign taken_s   = bus.exmem_branch & bus.exmem_zero;
  // Abort fires on the last allowed wait cycle if memory still has not answered.
  assign timeout_s = (state_q == MEM_WAIT) && !bus.dmem_ready && (wait_cnt_q == WC_LAST);
  assign freeze_s  = !bus.dmem_ready &&
                     (((state_q == RUN) && memop_s) || ((state_q == MEM_WAIT) && !timeout_s));

  // Priority mux for pipeline controls plus next-state for FSM and counters.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_err_d      = mem_err_q;
    stall_cycles_d = stall_cycles_q;
    pc_write_s     = 1'b1;
    pc_src_s       = 1'b0;
    ifid_write_s   = 1'b1;
    ifid_flush_s   = 1'b0;
    idex_write_s   = 1'b1;
    idex_flush_s   = 1'b0;
    exmem_write_s  = 1'b1;
    exmem_flush_s  = 1'b0;
    dmem_req_s     = memop_s;
    if (reset) begin
      pc_write_s     = 1'b0;
      ifid_write_s   = 1'b0;
      ifid_flush_s   = 1'b1;
      idex_write_s   = 1'b0;
      idex_flush_s   = 1'b1;
      exmem_write_s  = 1'b0;
      exmem_flush_s  = 1'b1;
      dmem_req_s     = 1'b0;
      state_d        = RUN;
      wait_cnt_d     = {WC_W{1'b0}};
      mem_err_d      = 1'b0;
      stall_cycles_d = {CNT_W{1'b0}};
    end else if (timeout_s) begin
      // Drop the stuck access; younger stages stay put.
      pc_write_s    = 1'b0;
      ifid_write_s  = 1'b0;
      idex_write_s  = 1'b0;
      exmem_write_s = 1'b0;
      exmem_flush_s = 1'b1;
      dmem_req_s    = 1'b0;
      mem_err_d     = 1'b1;
      state_d       = RUN;
      wait_cnt_d    = {WC_W{1'b0}};
    end else if (freeze_s) begin
      pc_write_s     = 1'b0;
      ifid_write_s   = 1'b0;
      idex_write_s   = 1'b0;
      exmem_write_s  = 1'b0;
      stall_cycles_d = (stall_cycles_q == CNT_MAX) ? stall_cycles_q
                                                   : stall_cycles_q + CNT_W'(1);
      if (state_q == RUN) begin
        state_d    = MEM_WAIT;
        wait_cnt_d = WC_W'(1);
      end else begin
        wait_cnt_d = wait_cnt_q + WC_W'(1);
      end
    end else begin
      // Memory answered (or no access): release and resolve control hazards now.
      state_d    = RUN;
      wait_cnt_d = {WC_W{1'b0}};
      if (taken_s) begin
        pc_src_s      = 1'b1;
        ifid_flush_s  = 1'b1;
        idex_flush_s  = 1'b1;
        exmem_flush_s = 1'b1;
      end else if (load_use_s) begin
        pc_write_s   = 1'b0;
        ifid_write_s = 1'b0;
        idex_flush_s = 1'b1;
      end else begin
        pc_src_s = 1'b0;
      end
    end
  end

  // State and counter registers; reset is folded into the next-state logic.
  always_ff @(posedge clk) begin
    state_q        <= state_d;
    wait_cnt_q     <= wait_cnt_d;
    mem_err_q      <= mem_err_d;
    stall_cycles_q <= stall_cycles_d;
  end

  assign bus.pc_write     = pc_write_s;
  assign bus.pc_src       = pc_src_s;
  assign bus.ifid_write   = ifid_write_s;
  assign bus.ifid_flush   = ifid_flush_s;
  assign bus.idex_write   = idex_write_s;
  assign bus.idex_flush   = idex_flush_s;
  assign bus.exmem_write  = exmem_write_s;
  assign bus.exmem_flush  = exmem_flush_s;
  assign bus.dmem_req     = dmem_req_s;
  assign bus.mem_err      = mem_err_q;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic.
module tb_pipe_hazard_ctrl;

  localparam int TMO   = 4;
  localparam int CNT_W = 4;
  localparam int MAXS  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             pc_write;
    logic             pc_src;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_flush;
    logic             exmem_write;
    logic             exmem_flush;
    logic             dmem_req;
    logic             mem_err;
    logic [CNT_W-1:0] stall;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   n_push = 0;
  int   n_pop = 0;
  exp_t sb[$];

  // Reference state: waiting on memory, cycles waited so far, sticky error, freeze count.
  bit m_wait = 0;
  int m_n = 0;
  bit m_err = 0;
  int m_stall = 0;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, predict the controls from the rules, advance the model.
  task automatic cyc(input bit chk, input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                     input bit mr, input logic [4:0] rd, input bit br, input bit z,
                     input bit emr, input bit emw, input bit rdy);
    exp_t e;
    bit memop, taken, lu, tmo, stuck;
    @(posedge clk);
    #1;
    reset = rst;
    bus.ifid_rs1 = rs1;      bus.ifid_rs2 = rs2;
    bus.idex_memread = mr;   bus.idex_rd = rd;
    bus.exmem_branch = br;   bus.exmem_zero = z;
    bus.exmem_memread = emr; bus.exmem_memwrite = emw;
    bus.dmem_ready = rdy;
    memop = emr || emw;
    taken = br && z;
    lu = mr && (rd != 5'd0) && (rd == rs1 || rd == rs2);
    e.mem_err = m_err;
    e.stall = CNT_W'(m_stall);
    e.pc_src = 1'b0;
    if (rst) begin
      {e.pc_write, e.ifid_write, e.idex_write, e.exmem_write} = 4'b0000;
      {e.ifid_flush, e.idex_flush, e.exmem_flush} = 3'b111;
      e.dmem_req = 1'b0;
      m_wait = 0; m_n = 0; m_err = 0; m_stall = 0;
    end else begin
      tmo = m_wait && !rdy && (m_n == TMO - 1);
      stuck = !rdy && (m_wait ? !tmo : memop);
      {e.pc_write, e.ifid_write, e.idex_write, e.exmem_write} = 4'b1111;
      {e.ifid_flush, e.idex_flush, e.exmem_flush} = 3'b000;
      e.dmem_req = memop;
      if (tmo) begin
        {e.pc_write, e.ifid_write, e.idex_write, e.exmem_write} = 4'b0000;
        e.exmem_flush = 1'b1;
        e.dmem_req = 1'b0;
        m_err = 1; m_wait = 0; m_n = 0;
      end else if (stuck) begin
        {e.pc_write, e.ifid_write, e.idex_write, e.exmem_write} = 4'b0000;
        if (m_stall < MAXS) m_stall++;
        if (m_wait) m_n++;
        else begin m_wait = 1; m_n = 1; end
      end else begin
        m_wait = 0; m_n = 0;
        if (taken) begin
          e.pc_src = 1'b1;
          {e.ifid_flush, e.idex_flush, e.exmem_flush} = 3'b111;
        end else if (lu) begin
          e.pc_write = 1'b0;
          e.ifid_write = 1'b0;
          e.idex_flush = 1'b1;
        end
      end
    end
    if (chk) begin
      sb.push_back(e);
      n_push++;
    end
  endtask

  task automatic idle(input bit rst);
    cyc(1, rst, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: every cycle with a pending prediction, compare all controller outputs.
  always @(negedge clk) begin
    exp_t a, e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '{bus.pc_write, bus.pc_src, bus.ifid_write, bus.ifid_flush, bus.idex_write,
            bus.idex_flush, bus.exmem_write, bus.exmem_flush, bus.dmem_req,
            bus.mem_err, bus.stall_cycles};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL ctrl_outs cyc=%0d got=%b want=%b (pcw,pcs,ifw,iff,idw,idf,exw,exf,req,err,stall)",
                 n_pop, a, e);
      end
      n_pop++;
    end
  end

  initial begin
    bus.ifid_rs1 = 5'd0; bus.ifid_rs2 = 5'd0; bus.idex_memread = 1'b0; bus.idex_rd = 5'd0;
    bus.exmem_branch = 1'b0; bus.exmem_zero = 1'b0; bus.exmem_memread = 1'b0;
    bus.exmem_memwrite = 1'b0; bus.dmem_ready = 1'b1;
    cyc(0, 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1);   // registers leave X
    idle(1); idle(1);
    idle(0);
    // load-use on rs2, then the load has moved on
    cyc(1, 0, 5'd1, 5'd5, 1, 5'd5, 0, 0, 0, 0, 1);
    idle(0);
    // load into x0 never stalls
    cyc(1, 0, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 0, 1);
    // taken branch with a pending load-use, then not-taken
    cyc(1, 0, 5'd3, 5'd0, 1, 5'd3, 1, 1, 0, 0, 1);
    cyc(1, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, 1);
    // load waits 3 cycles, released on the 4th
    for (int i = 0; i < 3; i++) cyc(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
    cyc(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 1);
    // zero-wait access
    cyc(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 1);
    idle(0);
    // illegal branch+memop: freeze first, branch taken on release
    cyc(1, 0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 1, 0, 0);
    cyc(1, 0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 1, 0, 1);
    // store never answered: abort on the 4th cycle, error stays set
    for (int i = 0; i < 5; i++) cyc(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0);
    cyc(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 1);
    idle(0); idle(0);
    // reset clears error and counter
    idle(1); idle(0);
    // reset asserted in the middle of a wait
    cyc(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
    cyc(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
    cyc(1, 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
    cyc(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
    cyc(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 1);
    // random traffic (counter saturates along the way)
    for (int i = 0; i < 3000; i++) begin
      bit emr, emw;
      emr = ($urandom_range(0, 7) == 0);
      emw = !emr && ($urandom_range(0, 7) == 0);
      cyc(1, ($urandom_range(0, 199) == 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          $urandom_range(0, 1), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
          emr, emw, ($urandom_range(0, 2) != 0));
    end
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0 || n_pop != n_push) begin
      bad++;
      $display("FAIL sb_drain left=%0d popped=%0d pushed=%0d", sb.size(), n_pop, n_push);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Detects load-use hazards in ID and resolves taken branches at the EX/MEM stage.
- Freezes the whole pipeline while a data-memory access in EX/MEM waits on a ready/valid-style handshake with timeout.
- Drives write-enables and flushes of IF/ID, ID/EX and EX/MEM, plus PC write/select.

Parameters:
MEM_TIMEOUT, 64, max cycles spent in MEM_WAIT before abort (>=2)
CNT_W, 16, width of saturating stall-cycle performance counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ifid_rs1  in  5  rs1 of instruction in IF/ID
ifid_rs2  in  5  rs2 of instruction in IF/ID
idex_memread  in  1  ID/EX Memread
idex_rd  in  5  ID/EX destination register
exmem_branch  in  1  EX/MEM Branch
exmem_zero  in  1  EX/MEM zero flag
exmem_memread  in  1  EX/MEM Memread
exmem_memwrite  in  1  EX/MEM Memwrite
dmem_ready  in  1  data memory completes current access this cycle
pc_write  out  1  PC register enable
pc_src  out  1  1 = load branch target (EX/MEM Adderout) into PC
ifid_write  out  1  IF/ID enable
ifid_flush  out  1  IF/ID clear
idex_write  out  1  ID/EX enable
idex_flush  out  1  ID/EX clear (bubble)
exmem_write  out  1  EX/MEM enable
exmem_flush  out  1  EX/MEM clear
dmem_req  out  1  data memory request
mem_err  out  1  sticky: a memory access timed out
stall_cycles  out  CNT_W  count of freeze cycles, saturating

Behaviour:
- Reset: clk, reset per decision above. While reset=1: state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0; all *_write=0, all *_flush=1, pc_src=0, dmem_req=0.
- Control outputs are Mealy (combinational from state + inputs); state, wait_cnt, mem_err, stall_cycles are registered.
- Default (no event): all *_write=1, all *_flush=0, pc_src=0.
- memop = exmem_memread | exmem_memwrite; dmem_req = memop in RUN or MEM_WAIT.
- taken = exmem_branch & exmem_zero.
- load_use = idex_memread & idex_rd!=0 & (idex_rd==ifid_rs1 | idex_rd==ifid_rs2).
- Priority per cycle: freeze > taken > load_use.
- Freeze: in RUN with memop & !dmem_ready, or in MEM_WAIT with !dmem_ready and no timeout.
  - pc_write=ifid_write=idex_write=exmem_write=0; no flushes.
  - stall_cycles += 1, saturating at all-ones.
- State RUN:
  - memop & !dmem_ready -> MEM_WAIT, wait_cnt<=1.
  - memop & dmem_ready -> zero-stall access, stay RUN.
- State MEM_WAIT:
  - dmem_ready -> RUN; freeze released in that same cycle; taken/load_use evaluated normally in that cycle.
  - !dmem_ready & wait_cnt==MEM_TIMEOUT-1 -> abort: mem_err<=1, exmem_flush=1, dmem_req=0, other stages held, next state RUN, wait_cnt<=0.
  - Otherwise wait_cnt += 1.
- Taken branch (no freeze): pc_src=1, pc_write=1, ifid_flush=idex_flush=exmem_flush=1. Squashes the 3 younger instructions; any load_use that cycle is ignored.
- Load-use (no freeze, no taken): pc_write=0, ifid_write=0, idex_flush=1. One bubble; the hazard clears the next cycle because the load moves to EX/MEM.
- Branch with memop simultaneously is illegal encoding; freeze wins, branch is then taken on the release cycle.
- mem_err is cleared only by reset.
- rd=x0 never causes a stall.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum {RUN, MEM_WAIT};
  - REG_W=5 constant;
  - default MEM_TIMEOUT.
- One natural sub-module: hazard_detect (pure combinational load_use compare), instantiated once.
- FSM, counters and priority mux stay in the top level.

Test Plan:
- Load-use: idex_memread=1, idex_rd=5, ifid_rs2=5 -> exactly one cycle pc_write=0, ifid_write=0, idex_flush=1; same with idex_rd=0 -> no stall.
- Taken branch: exmem_branch=1, exmem_zero=1 -> pc_src=1 and all three flushes=1 for one cycle; with exmem_zero=0 -> defaults.
- Memory wait: exmem_memread=1, dmem_ready low 3 cycles then high -> 3 freeze cycles, release on 4th, stall_cycles=3, dmem_req high all 4.
- Zero-wait access: memop with dmem_ready=1 same cycle -> no freeze, state stays RUN, stall_cycles unchanged.
- Timeout: MEM_TIMEOUT=4, memwrite, dmem_ready never high -> abort cycle 4 with exmem_flush=1, mem_err=1 sticky, state RUN; a later reset clears mem_err and the counter.
- Reset mid-wait: reset asserted in MEM_WAIT -> next cycle state RUN, wait_cnt=0, outputs at reset values while reset=1.
